// File: rtl/dec_fn_pkg.sv
// dec_fn_pkg: shared widths, mask type and the one-hot decode helper
// used by the dec_fn_pipe decoder/function-generator slice.
package dec_fn_pkg;

  // Widest select the slice supports. onehot() returns a vector sized for it.
  localparam int N_MAX = 6;
  localparam int N     = 3;
  localparam int W     = 1 << N;

  typedef logic [W-1:0] mask_t;

  // Returns 1 << w over 2^N_MAX lines, or all zero when en is low.
  // Select bits above n are dropped, so callers can truncate to 2^n lines.
  function automatic logic [(1<<N_MAX)-1:0] onehot(input int n,
                                                   input logic [N_MAX-1:0] w,
                                                   input logic en);
    logic [N_MAX-1:0] wm;
    wm = w & N_MAX'((1 << n) - 1);
    onehot = '0;
    onehot[wm] = en;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational N-to-2^N decoder with enable.
module dec_onehot
  import dec_fn_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]      w,
  input  logic              en,
  output logic [(1<<N)-1:0] y
);

  localparam int WID = 1 << N;

  assign y = WID'(onehot(N, N_MAX'(w), en));

endmodule

// File: rtl/dec_fn_pipe.sv
// dec_fn_pipe: two-stage registered decoder plus programmable minterm
// function f = |(y & mask). Optional saturating hit counter under the
// HIT_CNT_EN macro; without it hit_cnt is constant zero.
module dec_fn_pipe
  import dec_fn_pkg::*;
#(
  parameter int               N        = 3,
  parameter int               CNT_W    = 16,
  parameter logic [(1<<N)-1:0] MASK_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [N-1:0]      w,
  input  logic              mask_we,
  input  logic [(1<<N)-1:0] mask_in,
  input  logic              cnt_clr,
  output logic [(1<<N)-1:0] y,
  output logic              f,
  output logic              out_valid,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int WID = 1 << N;

  logic           s1_valid;
  logic [WID-1:0] s1_y;
  logic [WID-1:0] dec_y;
  logic [WID-1:0] mask_q;
  logic           hit;

  dec_onehot #(.N(N)) u_dec (
    .w  (w),
    .en (en),
    .y  (dec_y)
  );

  // Stage 2 reads the mask as it was before the current edge, so a write
  // never splits a result between old and new mask.
  assign hit = |(s1_y & mask_q);

  // Minterm mask register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask_q <= MASK_RST;
    else if (mask_we) mask_q <= mask_in;
  end

  // Stage 1: capture decoded lines; hold them across idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_y <= dec_y;
    end
  end

  // Stage 2: publish lines and function result; y/f hold when no result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      f         <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y <= s1_y;
        f <= hit;
      end
    end
  end

`ifdef HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of valid f=1 results; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cnt_q <= '0;
    else if (cnt_clr)                          cnt_q <= '0;
    else if (s1_valid && hit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign hit_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_dec_fn_pipe.sv
// tb_dec_fn_pipe: table-driven and randomized check of dec_fn_pipe (N=3,
// CNT_W=2). Reference model: each applied sample becomes a queued result
// record that must appear two edges later; the mask seen by a sample is the
// mask after all writes up to and including its own cycle.
module tb_dec_fn_pipe;

  localparam int N     = 3;
  localparam int W     = 1 << N;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, in_valid, mask_we, cnt_clr;
  logic [N-1:0]     w;
  logic [W-1:0]     mask_in;
  logic [W-1:0]     y;
  logic             f, out_valid;
  logic [CNT_W-1:0] hit_cnt;

  dec_fn_pipe #(.N(N), .CNT_W(CNT_W), .MASK_RST('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .w         (w),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .cnt_clr   (cnt_clr),
    .y         (y),
    .f         (f),
    .out_valid (out_valid),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] y;
    logic         f;
  } rec_t;

  typedef struct {
    logic [N-1:0] w;
    logic [W-1:0] ey;
    logic         ef;
  } vec_t;

  rec_t         q[$];
  logic [W-1:0] mm;     // model mask
  logic         ev, ef;
  logic [W-1:0] ey;
  int           mc;     // model hit count
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ev = 1'b0; ey = '0; ef = 1'b0; mm = '0; mc = 0;
  endtask

  // Apply one cycle of stimulus at a negedge, advance to the next negedge,
  // then compare every output against the model.
  task automatic cyc(input logic iv, input logic e, input logic [N-1:0] ww,
                     input logic we, input logic [W-1:0] mi, input logic clr);
    rec_t r, p;
    in_valid = iv; en = e; w = ww; mask_we = we; mask_in = mi; cnt_clr = clr;
    if (we) mm = mi;
    r.v = iv;
    r.y = e ? W'(1) << ww : '0;
    r.f = (r.y & mm) != '0;
    q.push_back(r);
    @(negedge clk);
    ev = 1'b0;
    if (q.size() > 1) begin
      p  = q.pop_front();
      ev = p.v;
      if (p.v) begin ey = p.y; ef = p.f; end
    end
    if (clr) mc = 0;
    else if (ev && ef && mc < (1 << CNT_W) - 1) mc++;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("y",         64'(y),         64'(ey));
    chk("f",         64'(f),         64'(ef));
`ifdef HIT_CNT_EN
    chk("hit_cnt",   64'(hit_cnt),   64'(mc));
`else
    chk("hit_cnt",   64'(hit_cnt),   64'd0);
`endif
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    vec_t tbl[8];
    int   hexp[5];
    tbl = '{'{3'd0, 8'h01, 1'b0}, '{3'd1, 8'h02, 1'b1}, '{3'd2, 8'h04, 1'b1},
            '{3'd3, 8'h08, 1'b0}, '{3'd4, 8'h10, 1'b1}, '{3'd5, 8'h20, 1'b0},
            '{3'd6, 8'h40, 1'b0}, '{3'd7, 8'h80, 1'b1}};
    hexp = '{1, 2, 3, 3, 3};

    rst = 1'b1; en = 0; in_valid = 0; w = '0; mask_we = 0; mask_in = '0; cnt_clr = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset y",         64'(y),         64'd0);

    // Full decode with XOR mask, back-to-back
    cyc(1'b0, 1'b0, '0, 1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, tbl[i].w, 1'b0, '0, 1'b0);
      if (i > 0) begin
        chk("tbl y", 64'(y), 64'(tbl[i-1].ey));
        chk("tbl f", 64'(f), 64'(tbl[i-1].ef));
      end
    end
    idle();
    chk("tbl y last", 64'(y), 64'(tbl[7].ey));
    chk("tbl f last", 64'(f), 64'(tbl[7].ef));
    idle();

    // Enable off with all-ones mask
    cyc(1'b0, 1'b0, '0, 1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, 3'd7, 1'b0, '0, 1'b0);
    idle();
    chk("en off y", 64'(y), 64'd0);
    chk("en off f", 64'(f), 64'd0);
    chk("en off valid", 64'(out_valid), 64'd1);

    // Gaps: 1,0,0,1 then let y/f hold
    cyc(1'b1, 1'b1, 3'd2, 1'b0, '0, 1'b0);
    idle(); idle();
    cyc(1'b1, 1'b1, 3'd6, 1'b0, '0, 1'b0);
    idle(); idle(); idle();

    // Mask hazard: w=3 streamed, write 00 -> 08 mid-stream
    cyc(1'b1, 1'b1, 3'd3, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 3'd3, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 3'd3, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 1'b0);
    chk("hazard old mask f", 64'(f), 64'd0);
    cyc(1'b1, 1'b1, 3'd3, 1'b0, '0, 1'b0);
    chk("hazard new mask f", 64'(f), 64'd1);
    idle();
    chk("hazard tail f", 64'(f), 64'd1);
    idle();

    // Hit counter saturation and clear-vs-increment
    cyc(1'b0, 1'b0, '0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b0, '0, 1'b0);
`ifdef HIT_CNT_EN
      if (i > 0) chk("hit seq", 64'(hit_cnt), 64'(hexp[i-1]));
`endif
    end
    cyc(1'b1, 1'b1, 3'd1, 1'b0, '0, 1'b0);
`ifdef HIT_CNT_EN
    chk("hit seq last", 64'(hit_cnt), 64'(hexp[4]));
`endif
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("clr beats hit", 64'(hit_cnt), 64'd0);
    idle();

    // Asynchronous reset mid-stream, after leaving a nonzero mask behind
    cyc(1'b1, 1'b1, 3'd4, 1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 3'd5, 1'b0, '0, 1'b0);
    in_valid = 1'b1; en = 1'b1; w = 3'd5; mask_we = 1'b0; cnt_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst y",         64'(y),         64'd0);
    chk("async rst f",         64'(f),         64'd0);
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst hit_cnt",   64'(hit_cnt),   64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1'b1, 1'b1, 3'd5, 1'b0, '0, 1'b0);
    chk("post rst valid0", 64'(out_valid), 64'd0);
    idle();
    chk("post rst y",     64'(y),         64'h20);
    chk("post rst f",     64'(f),         64'd0);
    chk("post rst valid", 64'(out_valid), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
          3'($urandom), 1'($urandom_range(0, 9) == 0), 8'($urandom),
          1'($urandom_range(0, 19) == 0));
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
